// File: rtl/pwm_modulator_mc.sv
// Multi-channel PWM generator with shared period counter, runtime prescaler,
// edge/center-aligned modes and double-buffered per-channel setpoints.
//
// Ports:
//   clk            system clock
//   nrst           asynchronous active-low reset
//   ena            global run; low clears counters and forces outputs low
//   prescale       one tick every prescale+1 clocks, read live
//   center_mode    0 edge-aligned, 1 center-aligned; applied at period start
//   ch_enable      per-channel enable; applied at period start
//   setpoint       packed setpoints, channel i at [i*MOD_WIDTH +: MOD_WIDTH]
//   setpoint_valid one-clock strobe loading all setpoints into pending
//   pwm_out        registered active-high PWM outputs
//   start_strobe   registered one-clock pulse at each period start
//   update_pending pending setpoints not yet applied
//   busy           registered copy of ena
module pwm_modulator_mc #(
    parameter int unsigned CH_NUM         = 4,
    parameter int unsigned MOD_WIDTH      = 8,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        ena,
    input  logic [PRESCALE_WIDTH-1:0]   prescale,
    input  logic                        center_mode,
    input  logic [CH_NUM-1:0]           ch_enable,
    input  logic [CH_NUM*MOD_WIDTH-1:0] setpoint,
    input  logic                        setpoint_valid,
    output logic [CH_NUM-1:0]           pwm_out,
    output logic                        start_strobe,
    output logic                        update_pending,
    output logic                        busy
);

    localparam logic [PRESCALE_WIDTH-1:0] PCNT_ONE = 1;
    localparam logic [MOD_WIDTH:0]        PH_ONE   = 1;

    logic [PRESCALE_WIDTH-1:0]   pcnt_q, pcnt_d;
    logic [MOD_WIDTH:0]          ph_q, ph_d;
    logic [CH_NUM*MOD_WIDTH-1:0] pend_q, pend_d;
    logic [CH_NUM*MOD_WIDTH-1:0] sp_sh_q, sp_sh_d;
    logic [CH_NUM-1:0]           en_sh_q, en_sh_d;
    logic                        mode_sh_q, mode_sh_d;
    logic                        upd_q, upd_d;
    logic                        wrap_q;
    logic                        busy_q;
    logic [CH_NUM-1:0]           pwm_q, pwm_d;
    logic                        strobe_q, strobe_d;

    logic                        tick;
    logic                        wrap;
    logic                        shadow_load;
    logic [MOD_WIDTH-1:0]        cnt;

    // >= rather than == so a lowered prescale ticks at once instead of
    // running the counter all the way round.
    assign tick = ena & (pcnt_q >= prescale);

    // Edge mode never sets the top phase bit, so only the low bits matter.
    assign wrap = tick & (mode_sh_q ? (&ph_q) : (&ph_q[MOD_WIDTH-1:0]));

    // While stopped the shadows track their sources so a restart begins
    // with the latest programming.
    assign shadow_load = ~ena | wrap;

    // Center mode folds the second half of the phase into a down-count.
    always_comb begin
        cnt = ph_q[MOD_WIDTH-1:0];
        if (mode_sh_q && ph_q[MOD_WIDTH]) begin
            cnt = ~ph_q[MOD_WIDTH-1:0];
        end
    end

    always_comb begin
        pcnt_d = pcnt_q;
        ph_d   = ph_q;
        if (!ena) begin
            pcnt_d = '0;
            ph_d   = '0;
        end else if (tick) begin
            pcnt_d = '0;
            ph_d   = wrap ? '0 : ph_q + PH_ONE;
        end else begin
            pcnt_d = pcnt_q + PCNT_ONE;
        end
    end

    always_comb begin
        pend_d    = setpoint_valid ? setpoint : pend_q;
        sp_sh_d   = sp_sh_q;
        en_sh_d   = en_sh_q;
        mode_sh_d = mode_sh_q;
        upd_d     = upd_q;
        if (shadow_load) begin
            sp_sh_d   = pend_q;
            en_sh_d   = ch_enable;
            mode_sh_d = center_mode;
            upd_d     = 1'b0;
        end
        // A strobe on the boundary lands in pending only and waits.
        if (setpoint_valid) begin
            upd_d = 1'b1;
        end
    end

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            pwm_d[i] = ena & en_sh_q[i]
                     & (cnt < sp_sh_q[i*MOD_WIDTH +: MOD_WIDTH]);
        end
    end

    // Fires for phase 0 on the first running clock and right after a wrap,
    // so it lines up with the first pwm sample of every period.
    assign strobe_d = ena & (ph_q == '0) & (~busy_q | wrap_q);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pcnt_q    <= '0;
            ph_q      <= '0;
            pend_q    <= '0;
            sp_sh_q   <= '0;
            en_sh_q   <= '0;
            mode_sh_q <= 1'b0;
            upd_q     <= 1'b0;
            wrap_q    <= 1'b0;
            busy_q    <= 1'b0;
            pwm_q     <= '0;
            strobe_q  <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            ph_q      <= ph_d;
            pend_q    <= pend_d;
            sp_sh_q   <= sp_sh_d;
            en_sh_q   <= en_sh_d;
            mode_sh_q <= mode_sh_d;
            upd_q     <= upd_d;
            wrap_q    <= wrap;
            busy_q    <= ena;
            pwm_q     <= pwm_d;
            strobe_q  <= strobe_d;
        end
    end

    assign pwm_out        = pwm_q;
    assign start_strobe   = strobe_q;
    assign update_pending = upd_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_pwm_modulator_mc.sv
// Randomized scoreboard bench for pwm_modulator_mc against a period-level
// reference model (clocks since tick, tick position within period).
module tb_pwm_modulator_mc;

    localparam int CH   = 4;
    localparam int MW   = 4;
    localparam int PSW  = 16;
    localparam int MAXV = (1 << MW) - 1;
    localparam int NCYC = 30000;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              ena = 1'b0;
    logic [PSW-1:0]    prescale = '0;
    logic              center_mode = 1'b0;
    logic [CH-1:0]     ch_enable = '0;
    logic [CH*MW-1:0]  setpoint = '0;
    logic              setpoint_valid = 1'b0;
    logic [CH-1:0]     pwm_out;
    logic              start_strobe;
    logic              update_pending;
    logic              busy;

    pwm_modulator_mc #(
        .CH_NUM(CH),
        .MOD_WIDTH(MW),
        .PRESCALE_WIDTH(PSW)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .ena(ena),
        .prescale(prescale),
        .center_mode(center_mode),
        .ch_enable(ch_enable),
        .setpoint(setpoint),
        .setpoint_valid(setpoint_valid),
        .pwm_out(pwm_out),
        .start_strobe(start_strobe),
        .update_pending(update_pending),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          st;
        logic          upd;
        logic          bsy;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    // Reference model state
    int   m_pend[CH];
    int   m_sp[CH];
    bit   m_en[CH];
    bit   m_mode;
    bit   m_upd;
    bit   m_busy;
    bit   m_wprev;
    int   m_div;
    int   m_pos;
    logic [CH-1:0] m_last_pwm;

    task automatic chk(input string nm, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h, expected %0h",
                     nm, $time, act, req);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < CH; i++) begin
            m_pend[i] = 0;
            m_sp[i]   = 0;
            m_en[i]   = 0;
        end
        m_mode     = 0;
        m_upd      = 0;
        m_busy     = 0;
        m_wprev    = 0;
        m_div      = 0;
        m_pos      = 0;
        m_last_pwm = '0;
    endfunction

    function automatic int m_plen();
        return m_mode ? 2 * (MAXV + 1) : MAXV + 1;
    endfunction

    function automatic bit m_bnd(input bit e, input int ps);
        return e && (m_div >= ps) && (m_pos == m_plen() - 1);
    endfunction

    // Advance the model by one clock and return the outputs after it.
    function automatic exp_t m_step(input bit e, input int ps, input bit cm,
                                    input logic [CH-1:0] ce,
                                    input logic [CH*MW-1:0] spv,
                                    input bit sv);
        exp_t r;
        int   plen;
        int   tri_v;
        bit   tk;
        bit   bnd;
        plen  = m_plen();
        tri_v = (m_pos <= MAXV) ? m_pos : plen - 1 - m_pos;
        for (int i = 0; i < CH; i++) begin
            r.pwm[i] = e && m_en[i] && (tri_v < m_sp[i]);
        end
        r.st = e && (m_pos == 0) && (!m_busy || m_wprev);
        tk   = e && (m_div >= ps);
        bnd  = tk && (m_pos == plen - 1);
        if (!e || bnd) begin
            for (int i = 0; i < CH; i++) begin
                m_sp[i] = m_pend[i];
                m_en[i] = ce[i];
            end
            m_mode = cm;
            m_upd  = 0;
        end
        if (!e) begin
            m_div = 0;
            m_pos = 0;
        end else if (tk) begin
            m_div = 0;
            m_pos = bnd ? 0 : m_pos + 1;
        end else begin
            m_div = m_div + 1;
        end
        m_wprev = bnd;
        if (sv) begin
            m_upd = 1;
            for (int i = 0; i < CH; i++) begin
                m_pend[i] = int'(spv[i*MW +: MW]);
            end
        end
        m_busy = e;
        r.upd  = m_upd;
        r.bsy  = e;
        return r;
    endfunction

    // Monitor: compare one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pwm_out", int'(pwm_out), int'(e.pwm));
                chk("start_strobe", int'(start_strobe), int'(e.st));
                chk("update_pending", int'(update_pending), int'(e.upd));
                chk("busy", int'(busy), int'(e.bsy));
            end
        end
    end

    // Stimulus
    initial begin
        int   seg_left;
        int   off_left;
        bit   arm;
        bit   bnd;
        exp_t r;
        int   sel;
        logic [MW-1:0] v;
        seg_left = 0;
        off_left = 0;
        arm      = 0;
        m_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            nrst = (cyc >= 3);
            if (seg_left == 0) begin
                seg_left = $urandom_range(40, 400);
                sel = $urandom_range(0, 5);
                case (sel)
                    0, 1:    prescale = '0;
                    2:       prescale = PSW'(1);
                    3:       prescale = PSW'(3);
                    4:       prescale = PSW'(40);
                    default: prescale = PSW'($urandom_range(2, 9));
                endcase
            end
            seg_left--;
            if (off_left > 0) begin
                off_left--;
                ena = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                off_left = $urandom_range(1, 6);
                ena = 1'b0;
            end else begin
                ena = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) ch_enable = CH'($urandom);
            if ($urandom_range(0, 299) == 0) center_mode = ~center_mode;
            bnd = m_bnd(ena, int'(prescale));
            setpoint_valid = bnd ? ($urandom_range(0, 2) == 0)
                                 : ($urandom_range(0, 49) == 0);
            if (setpoint_valid) begin
                for (int i = 0; i < CH; i++) begin
                    sel = $urandom_range(0, 5);
                    if (sel == 0) v = '0;
                    else if (sel == 1) v = MW'(MAXV);
                    else v = MW'($urandom);
                    setpoint[i*MW +: MW] = v;
                end
            end
            if ((cyc % 7000) == 6999) arm = 1;
            if (nrst && arm && ena && m_last_pwm != '0) begin
                arm  = 0;
                nrst = 1'b0;
                #1;
                chk("async_rst_pwm", int'(pwm_out), 0);
                chk("async_rst_strobe", int'(start_strobe), 0);
                chk("async_rst_upd", int'(update_pending), 0);
                chk("async_rst_busy", int'(busy), 0);
            end
            if (!nrst) begin
                m_reset();
                r = '0;
            end else begin
                r = m_step(ena, int'(prescale), center_mode, ch_enable,
                           setpoint, setpoint_valid);
            end
            m_last_pwm = r.pwm;
            q.push_back(r);
        end
        @(negedge clk);
        setpoint_valid = 1'b0;
        for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
